// File: rtl/mcs6530_pkg.sv
// Shared types and constants for the mcs6530 RRIOT bus master.
package mcs6530_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;

  localparam logic [ADDR_W-1:0] IDLE_ADDR    = 10'h000;
  localparam logic [DATA_W-1:0] DEF_ERR_DATA = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    WAIT,
    RESP
  } bus_state_t;

  // One upstream request as presented on the req_* channel
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic              rs0;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

  // Read latency is only meaningful in 1..7 (3-bit down-counter)
  function automatic int unsigned clamp_rd_lat(input int lat);
    if (lat < 1) return 1;
    if (lat > 7) return 7;
    return unsigned'(lat);
  endfunction

endpackage

// File: rtl/mcs6530_bus_master.sv
// Sequences single read/write requests into 6502-style phi2 bus cycles
// toward an mcs6530 RRIOT and returns read data on a response channel.
module mcs6530_bus_master
  import mcs6530_pkg::*;
#(
  parameter int                RD_LAT   = 1,
  parameter logic [DATA_W-1:0] ERR_DATA = DEF_ERR_DATA
) (
  input  logic              phi2,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_rs0,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_r_w,
  output logic              bus_cs1,
  output logic              bus_rs0,
  output logic [DATA_W-1:0] bus_di,
  input  logic [DATA_W-1:0] bus_do,
  input  logic              bus_oe
);

  localparam int unsigned       RD_LAT_C = clamp_rd_lat(RD_LAT);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(RD_LAT_C - 1);

  bus_state_t        state_q, state_d;
  logic              we_q, we_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              req_ready_d;
  logic              rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic              rsp_err_d;
  logic [ADDR_W-1:0] bus_addr_d;
  logic              bus_r_w_d;
  logic              bus_cs1_d;
  logic              bus_rs0_d;
  logic [DATA_W-1:0] bus_di_d;

  bus_req_t          req_in;

  assign req_in = '{we: req_we, addr: req_addr, rs0: req_rs0, wdata: req_wdata};

  // State and registered outputs; reset forces the bus idle immediately
  always_ff @(posedge phi2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      bus_addr  <= IDLE_ADDR;
      bus_r_w   <= 1'b1;
      bus_cs1   <= 1'b0;
      bus_rs0   <= 1'b0;
      bus_di    <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      cnt_q     <= cnt_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      bus_addr  <= bus_addr_d;
      bus_r_w   <= bus_r_w_d;
      bus_cs1   <= bus_cs1_d;
      bus_rs0   <= bus_rs0_d;
      bus_di    <= bus_di_d;
    end
  end

  // Next-state and next-output logic; everything holds unless a state changes it
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    bus_addr_d  = bus_addr;
    bus_r_w_d   = bus_r_w;
    bus_cs1_d   = bus_cs1;
    bus_rs0_d   = bus_rs0;
    bus_di_d    = bus_di;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d        = req_in.we;
          bus_addr_d  = req_in.addr;
          bus_rs0_d   = req_in.rs0;
          bus_cs1_d   = 1'b1;
          bus_r_w_d   = !req_in.we;
          bus_di_d    = req_in.we ? req_in.wdata : '0;
          req_ready_d = 1'b0;
          state_d     = SETUP;
        end
      end

      SETUP: begin
        state_d = ACCESS;
      end

      ACCESS: begin
        if (we_q) begin
          bus_r_w_d   = 1'b1;
          bus_cs1_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (cnt_q == '0) begin
          rsp_rdata_d = bus_oe ? bus_do : ERR_DATA;
          rsp_err_d   = !bus_oe;
          rsp_valid_d = 1'b1;
          bus_cs1_d   = 1'b0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mcs6530_bus_master.sv
// Randomized self-checking bench for mcs6530_bus_master with a simple chip stub.
module tb_mcs6530_bus_master;

  localparam int         RD_LAT = 1;
  localparam logic [7:0] ERR    = 8'hFF;

  logic       phi2;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [9:0] req_addr;
  logic       req_rs0;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic [9:0] bus_addr;
  logic       bus_r_w;
  logic       bus_cs1;
  logic       bus_rs0;
  logic [7:0] bus_di;
  logic [7:0] bus_do;
  logic       bus_oe;

  logic       oe_en;
  logic [7:0] chip_mem [2048];
  logic [7:0] ref_mem  [2048];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_acc = 0;
  logic prev_stream = 1'b0;
  logic prev_we = 1'b0;

  mcs6530_bus_master #(.RD_LAT(RD_LAT), .ERR_DATA(ERR)) dut (
    .phi2      (phi2),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_rs0   (req_rs0),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .bus_addr  (bus_addr),
    .bus_r_w   (bus_r_w),
    .bus_cs1   (bus_cs1),
    .bus_rs0   (bus_rs0),
    .bus_di    (bus_di),
    .bus_do    (bus_do),
    .bus_oe    (bus_oe)
  );

  initial phi2 = 1'b0;
  always #5 phi2 = ~phi2;

  always @(posedge phi2) cyc <= cyc + 1;

  // Chip stub: byte RAM keyed by {rs0, addr}; OE only while selected for read
  initial for (int i = 0; i < 2048; i++) chip_mem[i] <= 8'h00;
  always @(posedge phi2) if (bus_cs1 && !bus_r_w) chip_mem[{bus_rs0, bus_addr}] <= bus_di;
  assign bus_do = chip_mem[{bus_rs0, bus_addr}];
  assign bus_oe = bus_cs1 && bus_r_w && oe_en;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One transaction; called and returning at posedge+1 phase.
  // stream=1 keeps rsp_ready high; otherwise the response is held for 'hold' cycles.
  task automatic run_txn(input logic we, input logic [9:0] addr, input logic rs0,
                         input logic [7:0] wdata, input logic oe, input logic stream,
                         input int hold);
    logic       acc_ok;
    logic       got_acc;
    logic       got_rsp;
    logic       exp_cs1;
    logic       exp_rw;
    logic [7:0] exp_data;
    int         waited;
    int         n;

    oe_en     = oe;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_rs0   = rs0;
    req_wdata = wdata;
    got_acc   = 1'b0;
    waited    = 0;
    for (int k = 0; k < 40; k++) begin
      acc_ok = req_ready;
      @(posedge phi2); #1;
      waited++;
      if (acc_ok) begin
        got_acc = 1'b1;
        break;
      end
    end
    req_valid = 1'b0;
    check("accept", 32'(got_acc), 32'(1));
    if (!got_acc) return;
    if (!prev_stream) check("accept_wait", 32'(waited), 32'(1));
    if (stream && prev_stream)
      check("spacing", 32'(cyc - last_acc), 32'(prev_we ? 4 : 4 + RD_LAT));
    last_acc  = cyc;
    rsp_ready = stream;

    if (we) begin
      ref_mem[{rs0, addr}] = wdata;
      exp_data = 8'h00;
    end else begin
      exp_data = oe ? ref_mem[{rs0, addr}] : ERR;
    end

    n = 0;
    got_rsp = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (rsp_valid) begin
        got_rsp = 1'b1;
        break;
      end
      exp_cs1 = (n < 2) || (!we && n < 2 + RD_LAT);
      exp_rw  = !(we && n < 2);
      check("bus_ctl", 32'({bus_cs1, bus_r_w}), 32'({exp_cs1, exp_rw}));
      if (exp_cs1) begin
        check("bus_addr", 32'({bus_rs0, bus_addr}), 32'({rs0, addr}));
        check("bus_di", 32'(bus_di), 32'(we ? wdata : 8'h00));
      end
      @(posedge phi2); #1;
      n++;
    end
    check("rsp_seen", 32'(got_rsp), 32'(1));
    if (!got_rsp) return;
    check("latency", 32'(n), 32'(we ? 2 : 2 + RD_LAT));
    check("rsp_rdata", 32'(rsp_rdata), 32'(exp_data));
    check("rsp_err", 32'(rsp_err), 32'(!we && !oe));
    check("bus_idle", 32'({bus_cs1, bus_r_w}), 32'(2'b01));
    check("req_ready_busy", 32'(req_ready), 32'(0));
    prev_stream = stream;
    prev_we     = we;
    if (stream) return;

    // Backpressure: a competing request must be ignored while RESP is held
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      req_we    = 1'($urandom);
      req_addr  = 10'($urandom);
      @(posedge phi2); #1;
      check("hold_valid", 32'(rsp_valid), 32'(1));
      check("hold_rdata", 32'({rsp_err, rsp_rdata}), 32'({!we && !oe, exp_data}));
      check("hold_bus", 32'({bus_cs1, bus_r_w, req_ready}), 32'(3'b010));
    end
    rsp_ready = 1'b1;
    @(posedge phi2); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    check("handshake", 32'({rsp_valid, req_ready, bus_cs1}), 32'(3'b010));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2048; i++) ref_mem[i] = 8'h00;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_rs0   = 1'b0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    oe_en     = 1'b1;

    #12;
    check("rst_ready_valid", 32'({req_ready, rsp_valid, rsp_err}), 32'(3'b100));
    check("rst_rdata", 32'(rsp_rdata), 32'(0));
    check("rst_bus", 32'({bus_addr, bus_r_w, bus_cs1, bus_rs0}), 32'({10'h000, 3'b100}));
    check("rst_di", 32'(bus_di), 32'(0));
    @(negedge phi2);
    rst_n = 1'b1;
    @(posedge phi2); #1;

    // Directed: write, read back, OE low, backpressure
    run_txn(1'b1, 10'h040, 1'b1, 8'hA5, 1'b1, 1'b0, 0);
    run_txn(1'b0, 10'h040, 1'b1, 8'h00, 1'b1, 1'b0, 0);
    run_txn(1'b0, 10'h040, 1'b1, 8'h00, 1'b0, 1'b0, 0);
    run_txn(1'b0, 10'h040, 1'b1, 8'h00, 1'b1, 1'b0, 5);

    // Stream of write/read pairs with rsp_ready tied high
    for (int i = 0; i < 16; i++) begin
      run_txn(1'b1, 10'(i), 1'b0, 8'($urandom), 1'b1, 1'b1, 0);
      run_txn(1'b0, 10'(i), 1'b0, 8'h00, 1'b1, 1'b1, 0);
    end

    // Random mix of modes, addresses, OE and backpressure
    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom), 10'($urandom_range(0, 15)), 1'($urandom), 8'($urandom),
              ($urandom_range(0, 7) != 0), 1'($urandom), int'($urandom_range(0, 3)));
    end

    // Drain any pending streamed response
    rsp_ready = 1'b1;
    repeat (2) begin
      @(posedge phi2); #1;
    end
    rsp_ready = 1'b0;
    prev_stream = 1'b0;

    // Reset asserted while a read sits in WAIT
    oe_en     = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 10'h003;
    req_rs0   = 1'b0;
    @(posedge phi2); #1;
    req_valid = 1'b0;
    repeat (2) begin
      @(posedge phi2); #1;
    end
    check("pre_rst_wait", 32'({bus_cs1, bus_r_w, rsp_valid}), 32'(3'b110));
    rst_n = 1'b0;
    #1;
    check("mid_rst_bus", 32'({bus_cs1, bus_r_w, rsp_valid}), 32'(3'b010));
    @(negedge phi2);
    rst_n = 1'b1;
    @(posedge phi2); #1;
    check("post_rst", 32'({req_ready, rsp_valid, bus_cs1}), 32'(3'b100));
    repeat (3) begin
      @(posedge phi2); #1;
    end
    check("rsp_dropped", 32'({rsp_valid, bus_cs1}), 32'(2'b00));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mcs6530_bus_master.md
Name: mcs6530_bus_master

Overview:
- Upstream bus-cycle generator that drives the mcs6530 RRIOT pins: address, R_W, CS1, RS0 and write data.
- Accepts single read/write requests on a valid/ready interface and sequences each one as a 6502-style bus cycle timed on phi2.
- On reads it captures DO, qualified by OE, and returns the byte on a valid/ready response channel.
- Sits between the simulation/test sequencer (or a future CPU stub) and the mcs6530 instance in the Verilator top.

Parameters:
- RD_LAT, 1: phi2 cycles from the end of ACCESS until DO/OE are sampled on a read (1..7).
- ERR_DATA, 8'hFF: rsp_rdata value returned when a read sees OE low.

Ports:
- phi2  input  1  system clock; all state changes on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request this cycle
- req_we  input  1  1=write, 0=read
- req_addr  input  10  target address A9..A0
- req_rs0  input  1  RS0 select (ROM vs RAM/IO)
- req_wdata  input  8  write data
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer takes response
- rsp_rdata  output  8  read data (0 for writes)
- rsp_err  output  1  read saw OE low
- bus_addr  output  10  to chip A
- bus_r_w  output  1  to chip R_W / we_n (1=read)
- bus_cs1  output  1  to chip CS1
- bus_rs0  output  1  to chip RS0
- bus_di  output  8  to chip DI
- bus_do  input  8  from chip DO
- bus_oe  input  1  from chip OE

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - bus_addr=0, bus_r_w=1, bus_cs1=0, bus_rs0=0, bus_di=0, internal wait counter=0.
- FSM states: IDLE, SETUP, ACCESS, WAIT, RESP.
- IDLE:
  - req_ready=1; bus idle (bus_cs1=0, bus_r_w=1).
  - On req_valid: latch we/addr/rs0/wdata; go to SETUP.
- SETUP (1 cycle):
  - bus_addr=latched addr, bus_rs0=latched rs0, bus_cs1=1, bus_r_w=!we, bus_di=wdata when writing, else 0.
  - Go to ACCESS.
- ACCESS (1 cycle):
  - All bus outputs held stable from SETUP.
  - Write: go to RESP; bus_r_w returns to 1 and bus_cs1 to 0 on the same edge.
  - Read: load counter=RD_LAT-1; go to WAIT.
- WAIT:
  - Bus held as in ACCESS.
  - Counter==0: sample bus_do/bus_oe, set rsp_rdata=oe?do:ERR_DATA and rsp_err=!oe, deassert bus_cs1, go to RESP.
  - Otherwise decrement the counter.
- RESP:
  - rsp_valid=1; outputs stay stable until rsp_ready.
  - On rsp_valid && rsp_ready: rsp_valid=0, go to IDLE.
  - Writes return rsp_rdata=0, rsp_err=0.
- req_ready is 1 only in IDLE; requests offered in any other state are ignored and not lost, since the requester holds valid.
- Latency:
  - Write: accept to rsp_valid = 3 edges.
  - Read: 3+RD_LAT edges.
  - Minimum repeat rate is one transaction per 4 cycles (write) or 4+RD_LAT (read) with rsp_ready tied high.
- Back-to-back: a request cannot be accepted in the RESP cycle; the earliest acceptance is in the following IDLE cycle.
- bus_r_w is never 0 while bus_cs1 is 0. bus_addr keeps the last value after a transaction; only bus_cs1 marks a valid cycle.
- Reset mid-transaction: bus returns to idle values immediately (async) and any pending response is dropped.
- Out-of-range RD_LAT is clamped to 1..7 at elaboration.

Decomposition:
- Shared package mcs6530_pkg:
  - state enum bus_state_t.
  - Localparams IDLE_ADDR=10'h000, ERR_DATA default, ADDR_W=10, DATA_W=8.
- No sub-module; a single FSM plus a 3-bit latency counter.

Test Plan:
- Reset: assert rst_n=0 mid-WAIT -> bus_cs1=0, bus_r_w=1, rsp_valid=0 within the same cycle; req_ready=1 after release.
- Write: req_we=1, addr=10'h040, rs0=1, wdata=8'hA5 -> SETUP/ACCESS show bus_r_w=0, bus_cs1=1, bus_di=A5 for exactly 2 cycles; rsp_valid at edge 3 with rdata=0, err=0.
- Read: write A5 to 10'h040, then read 10'h040 with RD_LAT=1 -> rsp_rdata=8'hA5, rsp_err=0, rsp_valid 4 edges after acceptance.
- OE low: read with bus_oe forced 0 -> rsp_rdata=8'hFF, rsp_err=1.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0, bus_cs1=0 throughout; the next request is accepted the cycle after IDLE is re-entered.
- Stream: 16 alternating write/read pairs to addr 0..15, rsp_ready=1 -> every read returns its written byte; 4-cycle write and 5-cycle read spacing observed.
